// File: rtl/forward_path_router.sv
// East/west forward-stage router: buffers spike packets in a small FIFO and steers the
// head to slot A (continue, dx adjusted), B (north) or C (south), each a registered ready/valid slot.
module forward_path_router #(
   parameter int DATA_WIDTH    = 32,
   parameter int DX_MSB        = 29,
   parameter int DX_LSB        = 21,
   parameter int DY_MSB        = 20,
   parameter int DY_LSB        = 12,
   parameter int ADD           = 1,
   parameter int LOG_DEPTH     = 2,
   parameter bit DY_ZERO_SOUTH = 1'b0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [DATA_WIDTH-1:0]              din,
   input  logic                               din_valid,
   output logic                               din_ready,
   output logic [DATA_WIDTH-1:0]              dout_a,
   output logic                               a_valid,
   input  logic                               a_ready,
   output logic [DATA_WIDTH-(DX_MSB-DY_MSB)-1:0] dout_b,
   output logic                               b_valid,
   input  logic                               b_ready,
   output logic [DATA_WIDTH-(DX_MSB-DY_MSB)-1:0] dout_c,
   output logic                               c_valid,
   input  logic                               c_ready,
   output logic [LOG_DEPTH:0]                 fifo_count
);

   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam int DXW   = DX_MSB - DX_LSB + 1;
   localparam int DYW   = DY_MSB - DY_LSB + 1;
   localparam int OW    = DATA_WIDTH - (DX_MSB - DY_MSB);
   localparam logic [DXW-1:0]     ADD_DX = DXW'(ADD);
   localparam logic [LOG_DEPTH:0] FULL   = (LOG_DEPTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [LOG_DEPTH-1:0]  wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] head, head_a;
   logic [OW-1:0]         head_t;
   logic [DXW-1:0]        dx;
   logic [DYW-1:0]        dy;
   logic                  empty, wr, to_a, to_c, pop_a, pop_b, pop_c, pop;

   assign din_ready = (fifo_count != FULL);
   assign empty     = (fifo_count == '0);
   assign wr        = din_valid && din_ready;

   assign head = mem[rd_ptr];
   assign dx   = head[DX_MSB:DX_LSB];
   assign dy   = head[DY_MSB:DY_LSB];

   // dy is two's complement; the zero case goes north or south by parameter
   assign to_a = (dx != '0);
   assign to_c = !to_a && (dy[DYW-1] || (DY_ZERO_SOUTH && (dy == '0)));

   // a slot can take the head if it is free or emptying on this edge
   assign pop_a = !empty && to_a && (!a_valid || a_ready);
   assign pop_b = !empty && !to_a && !to_c && (!b_valid || b_ready);
   assign pop_c = !empty && to_c && (!c_valid || c_ready);
   assign pop   = pop_a || pop_b || pop_c;

   always_comb begin
      head_a = head;
      head_a[DX_MSB:DX_LSB] = dx + ADD_DX;
   end

   generate
      if (DX_MSB == DATA_WIDTH-1) begin : g_no_upper
         assign head_t = head[DX_LSB-1:0];
      end else begin : g_upper
         assign head_t = {head[DATA_WIDTH-1:DX_MSB+1], head[DX_LSB-1:0]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_valid <= 1'b0;
         b_valid <= 1'b0;
         c_valid <= 1'b0;
         dout_a  <= '0;
         dout_b  <= '0;
         dout_c  <= '0;
      end else begin
         if (pop_a) begin
            dout_a  <= head_a;
            a_valid <= 1'b1;
         end else if (a_valid && a_ready) begin
            a_valid <= 1'b0;
         end
         if (pop_b) begin
            dout_b  <= head_t;
            b_valid <= 1'b1;
         end else if (b_valid && b_ready) begin
            b_valid <= 1'b0;
         end
         if (pop_c) begin
            dout_c  <= head_t;
            c_valid <= 1'b1;
         end else if (c_valid && c_ready) begin
            c_valid <= 1'b0;
         end
      end
   end

endmodule
